pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the instruction-fetch unit. It replaces the fixed PC register with several additions: a valid/ready handshake to fetch, stall support, a one-entry pending-redirect buffer, separate trap and branch redirect ports, target legality checking with fault reporting, and a halt state. It sits at the head of the IFU, between the hazard/EX/CSR redirect sources and instruction memory.

## Interface
Parameters:
- XLEN, 32, PC and address width.
- BOOT_ADDR, 32'h0000_0000, PC value loaded by reset.
- IMEM_BASE, 32'h0000_0000, lowest legal fetch address.
- IMEM_SIZE, 32'h0000_1000, legal fetch window size in bytes. The legal window is IMEM_BASE ≤ a < IMEM_BASE+IMEM_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a fetch request.
- pc_ready  in  1  fetch accepts pc this cycle.
- stall  in  1  hazard unit freezes the frontend.
- br_valid  in  1  branch/jump redirect from EX.
- br_addr  in  XLEN  branch target.
- trap_valid  in  1  trap/mret redirect from CSR unit.
- trap_addr  in  XLEN  trap target.
- fetch_is_c  in  1  current instruction is 16-bit (used only with the macro).
- fault  out  1  one-cycle pulse: illegal fetch target.
- fault_cause  out  2  2'b01 misaligned, 2'b10 out of range.
- fault_addr  out  XLEN  offending target.
- state  out  2  BOOT=0, RUN=1, HALT=2 (debug).

## Operation
- fire = pc_valid & pc_ready & ~stall.
- step = 4. With COMPRESSED_EN, step = fetch_is_c ? 2 : 4. Sum is pc+step modulo 2^XLEN.
- Alignment mask: bits[1:0]==0. With COMPRESSED_EN, bit[0]==0.
- Legal(a) means aligned, and a lies within the legal window.

States:
- **BOOT**
  - Entered by rst. pc_valid=0.
  - The next cycle goes to RUN.
  - trap_valid is honored: aligned trap_addr is loaded and state goes to RUN. br_valid is ignored.
- **RUN**
  - pc_valid=1. Per-cycle priority:
    1. trap_valid: pc ← trap_addr with alignment bits cleared. The target is not range-checked. This applies even while stall=1, and clears pending.
    2. br_valid & ~stall: if legal, pc ← br_addr and pending is cleared. Otherwise a fault is raised.
    3. br_valid & stall: the branch is latched into pending, overwriting any older pending branch. pc holds.
    4. pending & ~stall: if legal, pc ← pending address and pending is cleared. Otherwise a fault is raised.
    5. fire: if pc+step is legal, pc ← pc+step. Otherwise a fault with cause 2'b10 is raised.
    6. Otherwise pc holds.
  - Redirects do not require pc_ready: a redirect flushes the outstanding request.
- **HALT**
  - pc_valid=0. pc holds its last legal value.
  - br_valid is ignored and pending is cleared.
  - Only trap_valid exits, by loading the aligned trap_addr and going to RUN.
- **Fault action:** pulse fault, load fault_cause and fault_addr, enter HALT, leave pc unchanged. When a target is both misaligned and out of range, cause 2'b01 wins.

## Timing
- All outputs are registered. A redirect or step is visible on pc in the cycle after it is sampled.
- Reset values: pc=BOOT_ADDR, pc_valid=0, state=BOOT, fault=0, fault_cause=0, fault_addr=0, pending empty.
- After rst falls, pc_valid rises one cycle later (one BOOT cycle).
- fault is high for exactly one cycle, in the same cycle state first reads HALT. fault_cause and fault_addr hold until the next fault or reset.
- Handshake: pc stays stable while pc_valid & ~pc_ready, unless a trap or branch redirect occurs.
- Boundary cases:
  - rst has priority over everything, mid-operation included.
  - trap and branch in the same cycle: trap wins and the branch is dropped.
  - Sequential fetch of the last word of the window raises an out-of-range fault. It does not wrap.

## Configuration
- COMPRESSED_EN, when defined:
  - Alignment granularity is 2 bytes.
  - step follows fetch_is_c.
  - trap_addr has bit[0] cleared.
- COMPRESSED_EN, when undefined:
  - Alignment granularity is 4 bytes.
  - step is always 4 and fetch_is_c is ignored.
  - trap_addr has bits[1:0] cleared.

## Test plan
All scenarios use default parameters, with COMPRESSED_EN undefined unless stated.
- **Reset and step:** release rst with pc_ready=1.
  - BOOT lasts 1 cycle, pc_valid=0, pc=0x0.
  - Then pc reads 0x0, 0x4, 0x8 on consecutive cycles.
- **Backpressure and stall:**
  - Hold pc_ready=0 for 3 cycles at pc=0x8: pc stays 0x8.
  - Drop stall and raise pc_ready: the next cycle pc=0xC.
- **Pending redirect:**
  - With stall=1, pulse br_valid with br_addr=0x100: pc holds.
  - Release stall: the next cycle pc=0x100.
  - A second branch to 0x200 issued during the same stall: pc becomes 0x200.
- **Priority:**
  - Same-cycle trap_addr=0x83 and br_addr=0x40: pc=0x80.
  - trap_valid during stall=1: it applies immediately.
- **Faults:**
  - br_addr=0x102: fault pulses once, cause 2'b01, fault_addr=0x102, state=HALT, pc_valid=0.
  - br_addr=0x2000: cause 2'b10.
  - Sequential fetch from pc=0xFFC: out-of-range fault.
  - In HALT, br_valid is ignored. trap_addr=0x40 gives pc=0x40 in RUN.
- **COMPRESSED_EN:**
  - With fetch_is_c=1, pc goes 0x0 → 0x2 → 0x4.
  - br_addr=0x102 is legal. br_addr=0x101 faults with cause 2'b01.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch handshake, redirect and fault bus of the program-counter generator.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic pc_valid;
  logic pc_ready;
  logic stall;
  logic br_valid;
  logic [XLEN-1:0] br_addr;
  logic trap_valid;
  logic [XLEN-1:0] trap_addr;
  logic fetch_is_c;
  logic fault;
  logic [1:0] fault_cause;
  logic [XLEN-1:0] fault_addr;
  logic [1:0] state;
  modport master (
    output pc, pc_valid, fault, fault_cause, fault_addr, state,
    input pc_ready, stall, br_valid, br_addr, trap_valid, trap_addr, fetch_is_c
  );
  modport slave (
    input pc, pc_valid, fault, fault_cause, fault_addr, state,
    output pc_ready, stall, br_valid, br_addr, trap_valid, trap_addr, fetch_is_c
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with handshake, stall, pending branch, trap/branch redirects, target checking and HALT.
// Define COMPRESSED_EN for 2-byte alignment and fetch_is_c-driven step.
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter logic [XLEN-1:0] IMEM_BASE = '0,
  parameter logic [XLEN-1:0] IMEM_SIZE = XLEN'('h1000)
) (
  input logic clk,
  input logic rst,
  pc_gen_if.master bus
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  logic [XLEN-1:0] step;
`ifdef COMPRESSED_EN
  localparam logic [1:0] AMASK = 2'b01;
  assign step = bus.fetch_is_c ? XLEN'(2) : XLEN'(4);
`else
  localparam logic [1:0] AMASK = 2'b11;
  logic unused_fetch_is_c;
  assign step = XLEN'(4);
  assign unused_fetch_is_c = bus.fetch_is_c;
`endif
  logic [1:0] st, st_n, fc, fc_n, why;
  logic [XLEN-1:0] pc_q, pc_n, paddr, paddr_n, fa, fa_n, tgt, trap_al;
  logic vld, pend, pend_n, flt, flt_n, chk, fire;
  // misaligned outranks out-of-range; window test avoids base+size overflow
  function automatic logic [1:0] cause(input logic [XLEN-1:0] a);
    return |(a[1:0] & AMASK) ? 2'b01 :
           (a < IMEM_BASE || a - IMEM_BASE >= IMEM_SIZE) ? 2'b10 : 2'b00;
  endfunction
  assign trap_al = bus.trap_addr & ~XLEN'(AMASK);
  assign fire = vld & bus.pc_ready & ~bus.stall;
  always_comb begin
    st_n = st;
    pc_n = pc_q;
    pend_n = pend;
    paddr_n = paddr;
    flt_n = 1'b0;
    fc_n = fc;
    fa_n = fa;
    chk = 1'b0;
    tgt = pc_q + step;
    if (st != RUN) begin
      pend_n = 1'b0;
      if (st == BOOT || bus.trap_valid) begin
        st_n = RUN;
        pc_n = bus.trap_valid ? trap_al : pc_q;
      end
    end else if (bus.trap_valid) begin
      pc_n = trap_al;
      pend_n = 1'b0;
    end else if (bus.br_valid) begin
      pend_n = bus.stall;
      paddr_n = bus.stall ? bus.br_addr : paddr;
      chk = ~bus.stall;
      tgt = bus.br_addr;
    end else if (pend & ~bus.stall) begin
      pend_n = 1'b0;
      chk = 1'b1;
      tgt = paddr;
    end else begin
      chk = fire;
    end
    why = cause(tgt);
    if (chk && why == 2'b00) begin
      pc_n = tgt;
    end else if (chk) begin
      st_n = HALT;
      pend_n = 1'b0;
      flt_n = 1'b1;
      fc_n = why;
      fa_n = tgt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= BOOT;
      pc_q <= BOOT_ADDR;
      vld <= 1'b0;
      pend <= 1'b0;
      paddr <= '0;
      flt <= 1'b0;
      fc <= 2'b00;
      fa <= '0;
    end else begin
      st <= st_n;
      pc_q <= pc_n;
      vld <= st_n == RUN;
      pend <= pend_n;
      paddr <= paddr_n;
      flt <= flt_n;
      fc <= fc_n;
      fa <= fa_n;
    end
  end
  assign bus.pc = pc_q;
  assign bus.pc_valid = vld;
  assign bus.state = st;
  assign bus.fault = flt;
  assign bus.fault_cause = fc;
  assign bus.fault_addr = fa;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table, compressed-mode sequence and randomized run against a reference model.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pc_gen_if #(.XLEN(32)) bus();
  pc_gen dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef COMPRESSED_EN
  localparam int ALIGN = 2;
`else
  localparam int ALIGN = 4;
`endif
  localparam longint BASE = 0;
  localparam longint SIZE = 'h1000;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic rst, stall, ready, bv;
    logic [31:0] ba;
    logic tv;
    logic [31:0] ta;
    logic [31:0] pc;
    logic vld;
    logic [1:0] st;
    logic flt;
    logic [1:0] fc;
    logic [31:0] fa;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(logic r, logic s, logic rd, logic bv, logic [31:0] ba, logic tv,
                              logic [31:0] ta, logic [31:0] pc, logic vld, logic [1:0] st,
                              logic flt, logic [1:0] fc, logic [31:0] fa);
    vec_t v;
    v.rst = r; v.stall = s; v.ready = rd; v.bv = bv; v.ba = ba; v.tv = tv; v.ta = ta;
    v.pc = pc; v.vld = vld; v.st = st; v.flt = flt; v.fc = fc; v.fa = fa;
    tbl.push_back(v);
  endfunction
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.pc_ready = 0; bus.br_valid = 0; bus.br_addr = 0;
    bus.trap_valid = 0; bus.trap_addr = 0; bus.fetch_is_c = 0;
  endtask
  // reference model: mode 0=BOOT 1=RUN 2=HALT, pending branch as a queue of at most one
  int m_mode;
  logic [31:0] m_pc, m_faddr;
  logic m_fault;
  logic [1:0] m_cause;
  logic [31:0] m_pq[$];
  function automatic int legal_why(logic [31:0] a);
    if (a % ALIGN != 0) return 1;
    return (longint'(a) >= BASE && longint'(a) < BASE + SIZE) ? 0 : 2;
  endfunction
  task automatic go_to(logic [31:0] a);
    int r;
    r = legal_why(a);
    if (r == 0) m_pc = a;
    else begin
      m_fault = 1; m_cause = 2'(r); m_faddr = a; m_mode = 2; m_pq.delete();
    end
  endtask
  task automatic model_step();
    logic [31:0] step, ta, a;
    step = (ALIGN == 2 && bus.fetch_is_c) ? 32'd2 : 32'd4;
    ta = bus.trap_addr - bus.trap_addr % ALIGN;
    m_fault = 0;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_cause = 0; m_faddr = 0; m_pq.delete();
    end else if (m_mode != 1) begin
      m_pq.delete();
      if (bus.trap_valid) begin m_pc = ta; m_mode = 1; end
      else if (m_mode == 0) m_mode = 1;
    end else if (bus.trap_valid) begin
      m_pc = ta; m_pq.delete();
    end else if (bus.br_valid && bus.stall) begin
      m_pq.delete(); m_pq.push_back(bus.br_addr);
    end else if (bus.br_valid) begin
      m_pq.delete(); go_to(bus.br_addr);
    end else if (m_pq.size() > 0 && !bus.stall) begin
      a = m_pq.pop_front(); go_to(a);
    end else if (bus.pc_ready && !bus.stall) begin
      go_to(m_pc + step);
    end
  endtask
  task automatic compare_model(int n);
    chk($sformatf("r%0d pc", n), bus.pc, m_pc);
    chk($sformatf("r%0d pc_valid", n), 32'(bus.pc_valid), 32'(m_mode == 1));
    chk($sformatf("r%0d state", n), 32'(bus.state), 32'(m_mode));
    chk($sformatf("r%0d fault", n), 32'(bus.fault), 32'(m_fault));
    chk($sformatf("r%0d fault_cause", n), 32'(bus.fault_cause), 32'(m_cause));
    chk($sformatf("r%0d fault_addr", n), bus.fault_addr, m_faddr);
  endtask
  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      5: return ($urandom_range(0, 4095) | 32'(1 << $urandom_range(0, 1)));
      6: return 32'h1000 + $urandom_range(0, 'h3000);
      7: return 32'hFF0 + 4 * $urandom_range(0, 3);
      default: return 4 * $urandom_range(0, 1023);
    endcase
  endfunction
  initial begin
    idle();
    rst = 1;
`ifndef COMPRESSED_EN
    //   rst s  rd bv ba      tv ta      | pc      v  st f  fc fa
    add(1, 0, 1, 0, 0,      0, 0,       0,      0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       0,      1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h4,    1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h8,    1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       'h8,    1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       'h8,    1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       'h8,    1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,      0, 0,       'h8,    1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'hC,    1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 'h100,  0, 0,       'hC,    1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,      0, 0,       'hC,    1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h100,  1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h104,  1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 'h180,  0, 0,       'h104,  1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 'h200,  0, 0,       'h104,  1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h200,  1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 'h40,   1, 'h83,    'h80,   1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       'h84,   1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,      1, 'h40,    'h40,   1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,      0, 0,       'h40,   1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 'h102,  0, 0,       'h40,   0, 2, 1, 1, 'h102);
    add(0, 0, 1, 0, 0,      0, 0,       'h40,   0, 2, 0, 1, 'h102);
    add(0, 0, 1, 1, 'h300,  0, 0,       'h40,   0, 2, 0, 1, 'h102);
    add(0, 0, 1, 0, 0,      1, 'h20,    'h20,   1, 1, 0, 1, 'h102);
    add(0, 0, 1, 1, 'h2000, 0, 0,       'h20,   0, 2, 1, 2, 'h2000);
    add(0, 0, 1, 0, 0,      1, 'hFF8,   'hFF8,  1, 1, 0, 2, 'h2000);
    add(0, 0, 1, 0, 0,      0, 0,       'hFFC,  1, 1, 0, 2, 'h2000);
    add(0, 0, 1, 0, 0,      0, 0,       'hFFC,  0, 2, 1, 2, 'h1000);
    add(1, 0, 1, 0, 0,      0, 0,       0,      0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0,      1, 'h42,    'h40,   1, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0,      0, 0,       0,      0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 'h100,  0, 0,       0,      1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,      0, 0,       0,      1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 'h3,    0, 0,       0,      1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0,      0, 0,       0,      0, 2, 1, 1, 'h3);
    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.stall = tbl[i].stall; bus.pc_ready = tbl[i].ready;
      bus.br_valid = tbl[i].bv; bus.br_addr = tbl[i].ba;
      bus.trap_valid = tbl[i].tv; bus.trap_addr = tbl[i].ta;
      tick();
      chk($sformatf("v%0d pc", i), bus.pc, tbl[i].pc);
      chk($sformatf("v%0d pc_valid", i), 32'(bus.pc_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("v%0d fault", i), 32'(bus.fault), 32'(tbl[i].flt));
      chk($sformatf("v%0d fault_cause", i), 32'(bus.fault_cause), 32'(tbl[i].fc));
      chk($sformatf("v%0d fault_addr", i), bus.fault_addr, tbl[i].fa);
    end
`else
    idle();
    rst = 1;
    tick();
    rst = 0; bus.pc_ready = 1; bus.fetch_is_c = 1;
    tick();
    chk("c boot exit pc", bus.pc, 0);
    tick();
    chk("c step 2", bus.pc, 'h2);
    tick();
    chk("c step 4", bus.pc, 'h4);
    bus.br_valid = 1; bus.br_addr = 'h102;
    tick();
    chk("c br 0x102 pc", bus.pc, 'h102);
    chk("c br 0x102 no fault", 32'(bus.fault), 0);
    bus.br_addr = 'h101;
    tick();
    chk("c br 0x101 fault", 32'(bus.fault), 1);
    chk("c br 0x101 cause", 32'(bus.fault_cause), 1);
    chk("c br 0x101 pc", bus.pc, 'h102);
    chk("c br 0x101 state", 32'(bus.state), 2);
    bus.br_valid = 0;
`endif
    idle();
    rst = 1;
    model_step();
    tick();
    compare_model(-1);
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      bus.stall = $urandom_range(0, 3) == 0;
      bus.pc_ready = $urandom_range(0, 3) != 0;
      bus.br_valid = $urandom_range(0, 3) == 0;
      bus.br_addr = rand_addr();
      bus.trap_valid = $urandom_range(0, 11) == 0;
      case ($urandom_range(0, 3))
        0: bus.trap_addr = 32'hFF0 + $urandom_range(0, 15);
        1: bus.trap_addr = $urandom;
        default: bus.trap_addr = $urandom_range(0, 4095);
      endcase
      bus.fetch_is_c = 1'($urandom_range(0, 1));
      model_step();
      tick();
      compare_model(n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
